ma_stage: RTL

//  Memory-access stage, directly downstream of the EX/MA pipeline register. Consumes the latched

---
 rtl/ma_stage_if.sv | 21 ++
 rtl/ma_stage.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ma_stage_if.sv
// Data-memory port bundle for the memory-access stage.
// master: the stage issuing requests; slave: the memory answering them.
interface ma_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
        output dmem_ready, dmem_rdata
    );
endinterface

// File: rtl/ma_stage.sv
// Memory-access pipeline stage: runs loads/stores over a req/ready port, resolves conditional
// branches and feeds the MA/WB register. Stalls upstream while an access is outstanding.
// Optional feature: define MA_MISALIGN_TRAP_EN to add misalign_o and suppress misaligned
// half/word accesses instead of silently ignoring the low address bits.
module ma_stage #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] ma_inst_i,
    input  logic [31:0] ma_pc_i,
    input  logic [31:0] ma_alu_out_i,
    input  logic [31:0] ma_rs2_data_i,
    input  logic        ma_branch_neq_i,
    input  logic        ma_branch_lt_i,
    ma_stage_if.master  dmem,
    output logic        stall_ma_o,
    output logic        branch_taken_o,
    output logic [31:0] branch_target_o,
    output logic [31:0] wb_inst_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_data_o,
`ifdef MA_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        bus_err_o
);

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [7:0] CntLast  = 8'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        bus_err_q, bus_err_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic        is_load, is_store, mem_op;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    assign opcode = ma_inst_i[6:0];
    assign funct3 = ma_inst_i[14:12];
    assign lane   = ma_alu_out_i[1:0];

    // Instruction class decode; unsupported funct3 under LOAD/STORE is a non-memory op
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        if (opcode == OpLoad) begin
            is_load = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        end
        if (opcode == OpStore) begin
            is_store = funct3 inside {3'b000, 3'b001, 3'b010};
        end
    end

`ifdef MA_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_load | is_store) &
                        (((funct3[1:0] == 2'b01) & lane[0]) |
                         ((funct3[1:0] == 2'b10) & (lane != 2'b00)));
    assign mem_op     = (is_load | is_store) & ~misaligned;
    assign misalign_o = misaligned;
`else
    assign mem_op     = is_load | is_store;
`endif

    // Store byte enables and lane replication
    always_comb begin
        dmem.dmem_wstrb = 4'b1111;
        dmem.dmem_wdata = ma_rs2_data_i;
        case (funct3[1:0])
            2'b00: begin
                dmem.dmem_wstrb = 4'b0001 << lane;
                dmem.dmem_wdata = {4{ma_rs2_data_i[7:0]}};
            end
            2'b01: begin
                dmem.dmem_wstrb = lane[1] ? 4'b1100 : 4'b0011;
                dmem.dmem_wdata = {2{ma_rs2_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign dmem.dmem_req  = (state_q == StReq);
    assign dmem.dmem_we   = is_store;
    assign dmem.dmem_addr = {ma_alu_out_i[31:2], 2'b00};

    // Extract and extend the load lane from the captured word
    always_comb begin
        ld_byte = rdata_q[8*lane +: 8];
        ld_half = lane[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    // Write-back data and pass-through fields
    always_comb begin
        wb_data_o = is_load ? ld_data : ma_alu_out_i;
`ifdef MA_MISALIGN_TRAP_EN
        if (misaligned) begin
            wb_data_o = 32'h0;
        end
`endif
    end

    assign wb_inst_o = ma_inst_i;
    assign wb_pc_o   = ma_pc_i;

    // Branch resolution from EX comparison flags; purely combinational
    always_comb begin
        branch_taken_o = 1'b0;
        if (opcode == OpBranch) begin
            case (funct3)
                3'b000:         branch_taken_o = ~ma_branch_neq_i;
                3'b001:         branch_taken_o = ma_branch_neq_i;
                3'b100, 3'b110: branch_taken_o = ma_branch_lt_i;
                3'b101, 3'b111: branch_taken_o = ~ma_branch_lt_i;
                default:        branch_taken_o = 1'b0;
            endcase
        end
    end

    assign branch_target_o = ma_alu_out_i;
    assign bus_err_o       = bus_err_q;

    // Access FSM next-state, timeout counter and stall
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        bus_err_d  = 1'b0;
        stall_ma_o = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_op) begin
                    stall_ma_o = 1'b1;
                    state_d    = StReq;
                end
            end
            StReq: begin
                stall_ma_o = 1'b1;
                if (dmem.dmem_ready) begin
                    rdata_d = dmem.dmem_rdata;
                    cnt_d   = 8'h0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    // Abort: the load reads as zero and the error is flagged for one cycle
                    rdata_d   = 32'h0;
                    cnt_d     = 8'h0;
                    bus_err_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + 8'h1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 8'h0;
            rdata_q   <= 32'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

endmodule
